ex_mem_pipe_reg: RTL
====================

// Module: ex_mem_pipe_reg
// PURPOSE
//  Parametrised EX->MEM pipeline register carrying the data address, read mode, write
//  enable and byte-quarter select from execute to the RAM/regfile side.
//  Adds valid/ready handshake, a one-entry skid buffer, pipeline flush and a stall counter.
//  Sits between the ALU address output and the data-RAM port; stalls when MEM back-pressures.
//  Single edge (posedge clk) capture.
// PARAMETERS
//  ADDR_W  16  width of data_addr
//  RDM_W   2   width of read_mem mode field
//  QTR_W   2   width of quarter select
//  SKID    1   1 = skid entry present, in_ready registered; 0 = single register, in_ready = !full | out_ready
//  CNT_W   16  width of stall_cnt
// PORTS
//  clk          in   1       clock, all state on posedge
//  rst_n        in   1       asynchronous active-low reset
//  flush        in   1       synchronous kill of all held entries
//  in_valid     in   1       EX presents a valid entry
//  in_ready     out  1       stage can accept this cycle
//  in_addr      in   ADDR_W  data address from EX
//  in_read_mem  in   RDM_W   read mode, 0 = no read
//  in_write_mem in   1       write enable
//  in_quarter   in   QTR_W   quarter select
//  out_valid    out  1       MEM-side entry valid
//  out_ready    in   1       MEM consumes entry this cycle
//  out_addr     out  ADDR_W  registered address
//  out_read_mem out  RDM_W   registered read mode, forced 0 when !out_valid
//  out_write_mem out 1       registered write enable, forced 0 when !out_valid
//  out_quarter  out  QTR_W   registered quarter
//  stall_cnt    out  CNT_W   saturating count of cycles with out_valid & !out_ready
// BEHAVIOUR
//  - Reset (rst_n=0, immediate): out_valid=0, all out_* fields=0, stall_cnt=0, skid empty,
//    in_ready=1. Reset mid-transfer discards all entries; no partial entry survives.
//  - Accept = in_valid & in_ready; consume = out_valid & out_ready. Latency 1 cycle in->out.
//  - States (SKID=1): EMPTY (main empty), MAIN (main valid), BOTH (main+skid valid).
//    EMPTY: accept -> MAIN.
//    MAIN: accept & !consume -> BOTH (input to skid); accept & consume -> MAIN (input to main);
//          !accept & consume -> EMPTY; else hold.
//    BOTH: consume -> MAIN (skid moves to main); else hold. in_ready=0 only in BOTH.
//  - in_ready is a register output when SKID=1 (no comb path from out_ready).
//  - Order preserved: skid entry always exits after main entry.
//  - Held entries are stable: out_* must not change while out_valid & !out_ready.
//  - Bubble safety: out_read_mem/out_write_mem gated to 0 whenever out_valid=0, so a
//    bubble never issues a RAM access; out_addr/out_quarter are don't-care but hold last value.
//  - flush: next state EMPTY, skid cleared, out_valid=0, in_ready=1. Flush beats a
//    simultaneous accept (input dropped) and a simultaneous consume (consume still counts).
//  - stall_cnt increments by 1 on each cycle out_valid & !out_ready; saturates at all-ones,
//    never wraps; unaffected by flush; cleared only by reset.
//  - SKID=0: only EMPTY/MAIN; accept allowed when EMPTY or consume this cycle.
// STRUCTURE
//  - Shared package: pipe state encoding (ST_EMPTY/ST_MAIN/ST_BOTH), packed entry
//    struct/width constant ENTRY_W = ADDR_W+RDM_W+1+QTR_W.
//  - One sub-module: pipe_skid_buf (generic ENTRY_W-wide skid buffer with valid/ready);
//    top level packs/unpacks fields, applies bubble gating, owns stall_cnt.
// TESTING
//  - Reset: drive rst_n=0 mid-stream -> out_valid=0, out_write_mem=0, in_ready=1 same cycle.
//  - Stream: out_ready=1, 4 entries addr 0x0010..0x0013 back-to-back -> appear 1 cycle later,
//    in order, in_ready stays 1.
//  - Back-pressure: out_ready=0 with addr 0x1234 held, send 0x5678 -> BOTH, in_ready=0,
//    out_addr stays 0x1234; release -> 0x1234 then 0x5678, no loss or duplicate.
//  - Flush in BOTH with in_valid=1 addr 0xBEEF -> next cycle out_valid=0, 0xBEEF never appears.
//  - Bubble: in_write_mem=1 with in_valid=0 -> out_write_mem stays 0.
//  - stall_cnt with CNT_W=4: hold out_ready=0 for 20 cycles -> reads 15, no wrap.

Source files
------------

// File: rtl/ex_mem_pipe_reg_pkg.sv
// ---------------------------------------------------------------------------
// ex_mem_pipe_reg_pkg
//   Shared definitions for the EX->MEM pipeline register:
//   - pipe_state_e : occupancy state of the skid buffer (EMPTY / MAIN / BOTH)
//   - entry_width(): width of one packed entry {addr, read_mem, write_mem, quarter}
//   - ADDR_W_DEF/RDM_W_DEF/QTR_W_DEF/ENTRY_W : default field widths
// ---------------------------------------------------------------------------
package ex_mem_pipe_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_BOTH  = 2'd2
    } pipe_state_e;

    localparam int ADDR_W_DEF = 16;
    localparam int RDM_W_DEF  = 2;
    localparam int QTR_W_DEF  = 2;

    // One entry = address + read mode + write enable (1 bit) + quarter select.
    function automatic int entry_width(input int addr_w, input int rdm_w, input int qtr_w);
        return addr_w + rdm_w + 1 + qtr_w;
    endfunction

    localparam int ENTRY_W = entry_width(ADDR_W_DEF, RDM_W_DEF, QTR_W_DEF);

endpackage

// File: rtl/pipe_skid_buf.sv
// ---------------------------------------------------------------------------
// pipe_skid_buf
//   Generic W-wide valid/ready pipeline register with an optional one-entry
//   skid buffer and a synchronous flush.
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     flush                drop every held entry (wins over accept)
//     in_valid/in_ready    upstream handshake
//     in_data [W-1:0]      upstream entry
//     out_valid/out_ready  downstream handshake
//     out_data [W-1:0]     downstream entry (the main register)
//   SKID=1: in_ready comes straight from a flop, so there is no combinational
//           path from out_ready to in_ready; the skid slot absorbs the one
//           entry that arrives while the consumer stalls.
//   SKID=0: single register, in_ready = empty | out_ready.
// ---------------------------------------------------------------------------
module pipe_skid_buf
    import ex_mem_pipe_reg_pkg::*;
#(
    parameter int W    = 8,
    parameter int SKID = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    pipe_state_e  state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_ready_q, in_ready_d;
    logic         accept, consume;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign in_ready = (state_q == ST_EMPTY) | out_ready;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = in_data;
                    state_d = ST_MAIN;
                end
            end
            ST_MAIN: begin
                if (accept && consume) begin
                    main_d = in_data;
                end else if (accept && (SKID != 0)) begin
                    // Consumer stalled: park the newcomer behind the held entry.
                    skid_d  = in_data;
                    state_d = ST_BOTH;
                end else if (consume) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_BOTH: begin
                if (consume) begin
                    main_d  = skid_q;
                    state_d = ST_MAIN;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (flush) begin
            state_d = ST_EMPTY;
        end

        // Registered ready: we can take data next cycle unless both slots fill.
        in_ready_d = (state_d != ST_BOTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_pipe_reg
//   EX->MEM pipeline register for the data-RAM request (address, read mode,
//   write enable, quarter select) with valid/ready handshake, skid buffer,
//   flush and a saturating stall counter.
//   Ports:
//     clk, rst_n                    clock, asynchronous active-low reset
//     flush                         synchronous kill of all held entries
//     in_valid/in_ready             EX-side handshake
//     in_addr/in_read_mem/
//     in_write_mem/in_quarter       request fields from EX
//     out_valid/out_ready           MEM-side handshake
//     out_addr/out_read_mem/
//     out_write_mem/out_quarter     registered request; read/write gated to 0
//                                   whenever out_valid=0
//     stall_cnt                     saturating count of out_valid & !out_ready
// ---------------------------------------------------------------------------
module ex_mem_pipe_reg
    import ex_mem_pipe_reg_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int RDM_W  = 2,
    parameter int QTR_W  = 2,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [RDM_W-1:0]  in_read_mem,
    input  logic              in_write_mem,
    input  logic [QTR_W-1:0]  in_quarter,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [RDM_W-1:0]  out_read_mem,
    output logic              out_write_mem,
    output logic [QTR_W-1:0]  out_quarter,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int EW = entry_width(ADDR_W, RDM_W, QTR_W);

    logic [EW-1:0]     in_entry, out_entry;
    logic [ADDR_W-1:0] f_addr;
    logic [RDM_W-1:0]  f_read_mem;
    logic              f_write_mem;
    logic [QTR_W-1:0]  f_quarter;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign in_entry = {in_addr, in_read_mem, in_write_mem, in_quarter};

    pipe_skid_buf #(
        .W    (EW),
        .SKID (SKID)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_entry)
    );

    assign {f_addr, f_read_mem, f_write_mem, f_quarter} = out_entry;

    // Bubbles must never reach the RAM as an access; address/quarter just hold.
    assign out_addr      = f_addr;
    assign out_quarter   = f_quarter;
    assign out_read_mem  = out_valid ? f_read_mem : '0;
    assign out_write_mem = out_valid & f_write_mem;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
